data_memory_responder: RTL

Responder end of the CPU data port on the Harvard MIPS core. It answers `data_read`/`data_write` strobes with a word-addressed RAM and provides a memory-mapped "tohost" output register. After reset it runs a self-clearing initialisation sequence, and it reports sticky protocol-error flags and saturating access counters so benches can check bus behaviour. It replaces the bare `data_memory` model in CPU benches and is also a synthesisable RAM slave.

---
 rtl/data_memory_responder_if.sv | 25 ++
 rtl/data_memory_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
// CPU data-port bundle between the core (master) and the data memory responder (slave).
// Read data comes back combinationally in the same cycle as the address and strobe.
interface data_memory_responder_if;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    modport master (
        output data_address,
        output data_write,
        output data_read,
        output data_writedata,
        input  data_readdata
    );

    modport slave (
        input  data_address,
        input  data_write,
        input  data_read,
        input  data_writedata,
        output data_readdata
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data-port responder for the Harvard MIPS core.
// It has a word-addressed RAM with combinational reads and a memory-mapped tohost register.
// After reset it clears the RAM one word per cycle.
// It also keeps sticky protocol-error flags and saturating read/write strobe counters.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_0000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    data_memory_responder_if.slave        bus,
    output logic                          init_done,
    output logic                          tohost_valid,
    output logic [31:0]                   tohost_data,
    output logic                          err_misaligned,
    output logic                          err_range,
    output logic                          err_conflict,
    output logic [CNT_W-1:0]              read_count,
    output logic [CNT_W-1:0]              write_count
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // The window bounds are held in 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(DEPTH_WORDS) << 2);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [AW-1:0]     idx_q;
    logic              init_done_q;
    logic              tohost_valid_q;
    logic [31:0]       tohost_data_q;
    logic              err_mis_q;
    logic              err_rng_q;
    logic              err_con_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_q;

    logic [31:0]       mem_q [DEPTH_WORDS];

    // Address decode
    logic              ready;
    logic              aligned;
    logic              in_ram;
    logic              is_tohost;
    logic [31:0]       offset;
    logic [AW-1:0]     word_idx;
    logic              rd_go;
    logic              wr_go;
    logic              strobe;
    logic              ram_wr;
    logic              th_wr;
    logic              mis_hit;
    logic              rng_hit;
    logic              unused_ok;

    // RAM write port
    logic              mem_we;
    logic [AW-1:0]     mem_wa;
    logic [31:0]       mem_wd;

    assign ready     = (state_q == S_READY);
    assign aligned   = (bus.data_address[1:0] == 2'b00);
    assign in_ram    = ({1'b0, bus.data_address} >= WIN_LO) &&
                       ({1'b0, bus.data_address} <  WIN_HI);
    assign is_tohost = (bus.data_address == TOHOST_ADDR);
    assign offset    = bus.data_address - BASE_ADDR;
    assign word_idx  = offset[AW+1:2];
    // The bits of offset above the word index are meaningful only when the address is out of range.
    // Out-of-range accesses are already caught by in_ram, so those bits are not used.
    assign unused_ok = ^offset;

    // Strobes are only acted upon once clearing has completed.
    assign rd_go   = ready & bus.data_read;
    assign wr_go   = ready & bus.data_write;
    assign strobe  = rd_go | wr_go;
    assign ram_wr  = wr_go & aligned & in_ram;
    assign th_wr   = wr_go & aligned & is_tohost;
    // Misalignment wins over range: a misaligned strobe sets only the misaligned flag.
    assign mis_hit = strobe & ~aligned;
    assign rng_hit = strobe & aligned & ~in_ram & ~is_tohost;

    // Saturating increment used by both strobe counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + 1'b1;
        end
        return v;
    endfunction

    // Combinational read: returns the word held before the edge, so a conflict cycle shows the pre-write data.
    always_comb begin
        bus.data_readdata = 32'h0;
        if (rd_go && aligned) begin
            if (in_ram) begin
                bus.data_readdata = mem_q[word_idx];
            end else if (is_tohost) begin
                bus.data_readdata = tohost_data_q;
            end
        end
    end

    // Select the single RAM write port: the clear sweep during CLEAR, or a bus write during READY.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = word_idx;
        mem_wd = bus.data_writedata;
        if (reset) begin
            if (state_q == S_CLEAR) begin
                mem_we = 1'b1;
                mem_wa = idx_q;
                mem_wd = 32'h0;
            end else if (ram_wr) begin
                mem_we = 1'b1;
            end
        end
    end

    // RAM array: this block has no reset because clearing is done by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Control FSM: clear sweep, tohost register, sticky error flags and strobe counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_CLEAR;
            idx_q          <= '0;
            init_done_q    <= 1'b0;
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= 32'h0;
            err_mis_q      <= 1'b0;
            err_rng_q      <= 1'b0;
            err_con_q      <= 1'b0;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    tohost_valid_q <= 1'b0;
                    idx_q          <= idx_q + 1'b1;
                    if (idx_q == AW'(DEPTH_WORDS - 1)) begin
                        state_q     <= S_READY;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    // The valid pulse lasts one cycle per write, so back-to-back writes keep it high.
                    tohost_valid_q <= th_wr;
                    if (th_wr) begin
                        tohost_data_q <= bus.data_writedata;
                    end
                    if (mis_hit) begin
                        err_mis_q <= 1'b1;
                    end
                    if (rng_hit) begin
                        err_rng_q <= 1'b1;
                    end
                    if (rd_go && wr_go) begin
                        err_con_q <= 1'b1;
                    end
                    rd_cnt_q <= sat_inc(rd_cnt_q, rd_go);
                    wr_cnt_q <= sat_inc(wr_cnt_q, wr_go);
                end
            endcase
        end
    end

    assign init_done      = init_done_q;
    assign tohost_valid   = tohost_valid_q;
    assign tohost_data    = tohost_data_q;
    assign err_misaligned = err_mis_q;
    assign err_range      = err_rng_q;
    assign err_conflict   = err_con_q;
    assign read_count     = rd_cnt_q;
    assign write_count    = wr_cnt_q;

endmodule
